// File: rtl/sfft_frame_pkg.sv
// ============================================================================
//  Module      : sfft_frame_pkg
//  Description : Shared definitions for the SFFT input framer. This package
//                holds the FSM state encoding, the sample type and the
//                bit-reverse helper used when SFFT_FRAME_BITREV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfft_frame_pkg;

    // Default sample width, matching the SFFT core input width.
    localparam int c_sample_width = 24;

    typedef logic signed [c_sample_width-1:0] sample_t;

    // Framer FSM encoding.
    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_copy      = 2'd1;
    localparam logic [1:0] c_st_wait_swap = 2'd2;

    // Reverse the low n_log bits of k. Bits above n_log are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int n_log);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n_log) begin
                r[i] = k[5'(n_log - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfft_frame_ring.sv
// ============================================================================
//  Module      : sfft_frame_ring
//  Description : Sample ring for the SFFT framer. It holds the last NFFT
//                accepted samples, the write pointer, the fill level and the
//                hop counter. A one-entry skid register catches a sample that
//                arrives while the framer is copying; a second one is lost and
//                flags a sticky overrun. The ring offers a combinational read
//                port driven by the copy address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfft_frame_ring
    import sfft_frame_pkg::*;
#(
    parameter int NFFT         = 32,
    parameter int N_LOG        = 5,
    parameter int SAMPLE_WIDTH = 24,
    parameter int HOP          = 8,
    parameter int HOP_WIDTH    = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           accept,
    input  logic                           copy_active,
    input  logic        [N_LOG-1:0]        rd_addr,
    output logic signed [SAMPLE_WIDTH-1:0] rd_data,
    output logic        [N_LOG-1:0]        ptr_after,
    output logic                           trigger,
    output logic                           overrun
);

    localparam logic [N_LOG:0]       c_fill_full  = (N_LOG + 1)'(NFFT);
    localparam logic [HOP_WIDTH-1:0] c_hop_target = HOP_WIDTH'(HOP);

    logic signed [SAMPLE_WIDTH-1:0] r_mem [NFFT];
    logic        [N_LOG-1:0]        r_wr_ptr;
    logic        [N_LOG:0]          r_fill;
    logic        [HOP_WIDTH-1:0]    r_hop;
    logic signed [SAMPLE_WIDTH-1:0] r_skid;
    logic                           r_skid_valid;
    logic                           r_overrun;

    logic                           w_commit_skid;
    logic                           w_commit_new;
    logic                           w_write;
    logic signed [SAMPLE_WIDTH-1:0] w_wdata;
    logic        [N_LOG:0]          w_fill_next;
    logic        [HOP_WIDTH-1:0]    w_hop_next;

    // A parked skid sample has priority over a fresh one once copying ends;
    // the fresh one then takes its place in the skid register.
    assign w_commit_skid = r_skid_valid && !copy_active;
    assign w_commit_new  = accept && !copy_active && !r_skid_valid;
    assign w_write       = w_commit_skid || w_commit_new;
    assign w_wdata       = w_commit_skid ? r_skid : sample_in;

    // Both counters saturate: fill at a full ring, hop at the target so a
    // narrow HOP_WIDTH never wraps while the ring is still filling.
    assign w_fill_next = (r_fill == c_fill_full) ? r_fill : r_fill + 1'b1;
    assign w_hop_next  = (r_hop >= c_hop_target) ? r_hop : r_hop + 1'b1;

    assign trigger   = w_write && (w_fill_next == c_fill_full) && (w_hop_next >= c_hop_target);
    assign ptr_after = w_write ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign rd_data   = r_mem[rd_addr];
    assign overrun   = r_overrun;

    // Ring storage write; the pointer wraps naturally since NFFT is a power of 2.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointer, fill level, hop counter, skid register and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_hop        <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_fill   <= w_fill_next;
                r_hop    <= trigger ? '0 : w_hop_next;
            end
            if (w_commit_skid) begin
                r_skid_valid <= accept;
                r_skid       <= sample_in;
            end else if (accept && copy_active) begin
                if (!r_skid_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid       <= sample_in;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sfft_frame_buffer.sv
// ============================================================================
//  Module      : sfft_frame_buffer
//  Description : Input framer for the SFFT. Converts the one-sample-per-strobe
//                audio stream into overlapping NFFT-point frames, HOP new
//                samples apart, and double-buffers them so the consumer reads
//                a stable front bank while the next frame is captured.
//                Optional macro SFFT_FRAME_BITREV_EN stores each frame in
//                bit-reversed order for a decimation-in-time butterfly core;
//                without it, address 0 is the oldest sample.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfft_frame_buffer
    import sfft_frame_pkg::*;
#(
    parameter int NFFT         = 32,
    parameter int N_LOG        = 5,
    parameter int SAMPLE_WIDTH = 24,
    parameter int HOP          = 8,
    parameter int HOP_WIDTH    = 6,
    parameter int DROP_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [SAMPLE_WIDTH-1:0] SampleAmplitudeIn,
    input  logic                           advanceSignal,
    input  logic                           OutputBeingRead,
    input  logic        [N_LOG-1:0]        output_address,
    output logic signed [SAMPLE_WIDTH-1:0] FrameSampleOut,
    output logic                           FrameValid,
    output logic                           FrameStrobe,
    output logic        [DROP_WIDTH-1:0]   FrameDropCount,
    output logic                           Overrun
);

    localparam logic [N_LOG-1:0] c_last_idx = N_LOG'(NFFT - 1);

    logic                           r_adv_prev;
    logic [1:0]                     r_state;
    logic [N_LOG-1:0]               r_copy_cnt;
    logic [N_LOG-1:0]               r_copy_base;
    logic                           r_front_sel;
    logic signed [SAMPLE_WIDTH-1:0] r_bank [2][NFFT];

    logic                           w_accept;
    logic                           w_trigger;
    logic [N_LOG-1:0]               w_ptr_after;
    logic [N_LOG-1:0]               w_ring_rd_addr;
    logic signed [SAMPLE_WIDTH-1:0] w_ring_rd_data;
    logic [N_LOG-1:0]               w_back_idx;
    logic                           w_last_copy;
    logic                           w_swap;

    assign w_accept       = advanceSignal && !r_adv_prev;
    assign w_ring_rd_addr = r_copy_base + r_copy_cnt;
    assign w_last_copy    = (r_state == c_st_copy) && (r_copy_cnt == c_last_idx);
    // The swap decision is taken on the last copy cycle or while waiting, so
    // the strobe and new front bank appear on the following cycle.
    assign w_swap         = (w_last_copy || (r_state == c_st_wait_swap)) && !OutputBeingRead;

`ifdef SFFT_FRAME_BITREV_EN
    assign w_back_idx = N_LOG'(bitrev(32'(r_copy_cnt), N_LOG));
`else
    assign w_back_idx = r_copy_cnt;
`endif

    sfft_frame_ring #(
        .NFFT         (NFFT),
        .N_LOG        (N_LOG),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .HOP          (HOP),
        .HOP_WIDTH    (HOP_WIDTH)
    ) u_ring (
        .clk         (clk),
        .rst         (reset),
        .sample_in   (SampleAmplitudeIn),
        .accept      (w_accept),
        .copy_active (r_state == c_st_copy),
        .rd_addr     (w_ring_rd_addr),
        .rd_data     (w_ring_rd_data),
        .ptr_after   (w_ptr_after),
        .trigger     (w_trigger),
        .overrun     (Overrun)
    );

    // Rising-edge detector on the sample strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adv_prev <= 1'b0;
        end else begin
            r_adv_prev <= advanceSignal;
        end
    end

    // Framer FSM: copy a full ring snapshot oldest-first, then swap banks or
    // wait for the consumer; a new trigger while waiting drops the old frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_copy_cnt  <= '0;
            r_copy_base <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_trigger) begin
                        r_state     <= c_st_copy;
                        r_copy_cnt  <= '0;
                        r_copy_base <= w_ptr_after;
                    end
                end
                c_st_copy: begin
                    r_copy_cnt <= r_copy_cnt + 1'b1;
                    if (w_last_copy) begin
                        r_state <= OutputBeingRead ? c_st_wait_swap : c_st_idle;
                    end
                end
                c_st_wait_swap: begin
                    if (w_trigger) begin
                        r_state     <= c_st_copy;
                        r_copy_cnt  <= '0;
                        r_copy_base <= w_ptr_after;
                    end else if (!OutputBeingRead) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Bank select, strobe, sticky valid flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_front_sel    <= 1'b0;
            FrameStrobe    <= 1'b0;
            FrameValid     <= 1'b0;
            FrameDropCount <= '0;
        end else begin
            r_front_sel <= r_front_sel ^ w_swap;
            FrameStrobe <= w_swap;
            FrameValid  <= FrameValid | w_swap;
            if ((r_state == c_st_wait_swap) && w_trigger && OutputBeingRead
                && (FrameDropCount != '1)) begin
                FrameDropCount <= FrameDropCount + 1'b1;
            end
        end
    end

    // Back-bank fill during COPY, one ring sample per cycle.
    always_ff @(posedge clk) begin
        if (r_state == c_st_copy) begin
            r_bank[~r_front_sel][w_back_idx] <= w_ring_rd_data;
        end
    end

    // Registered front-bank read; reads zero until the first frame lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            FrameSampleOut <= '0;
        end else begin
            FrameSampleOut <= FrameValid ? r_bank[r_front_sel][output_address] : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sfft_frame_buffer.sv
// ============================================================================
//  Module      : tb_sfft_frame_buffer
//  Description : Self-checking bench for sfft_frame_buffer (NFFT=8, HOP=4).
//                Directed frame scenarios followed by randomized traffic, all
//                compared against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfft_frame_buffer;

    localparam int NFFT       = 8;
    localparam int N_LOG      = 3;
    localparam int SW         = 24;
    localparam int HOP        = 4;
    localparam int HOP_WIDTH  = 3;
    localparam int DROP_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [SW-1:0]        sample = '0;
    logic                 advanceSignal = 1'b0;
    logic                 OutputBeingRead = 1'b0;
    logic [N_LOG-1:0]     output_address = '0;
    logic signed [SW-1:0] FrameSampleOut;
    logic                 FrameValid;
    logic                 FrameStrobe;
    logic [DROP_WIDTH-1:0] FrameDropCount;
    logic                 Overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sfft_frame_buffer #(
        .NFFT         (NFFT),
        .N_LOG        (N_LOG),
        .SAMPLE_WIDTH (SW),
        .HOP          (HOP),
        .HOP_WIDTH    (HOP_WIDTH),
        .DROP_WIDTH   (DROP_WIDTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .SampleAmplitudeIn (sample),
        .advanceSignal     (advanceSignal),
        .OutputBeingRead   (OutputBeingRead),
        .output_address    (output_address),
        .FrameSampleOut    (FrameSampleOut),
        .FrameValid        (FrameValid),
        .FrameStrobe       (FrameStrobe),
        .FrameDropCount    (FrameDropCount),
        .Overrun           (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [SW-1:0] m_ring[$];
    logic [SW-1:0] m_skid[$];
    logic [SW-1:0] m_snap [NFFT];
    logic [SW-1:0] m_front [NFFT];
    logic [SW-1:0] m_out;
    int  m_hop, m_copy_rem, m_drop;
    bit  m_wait, m_valid, m_strobe, m_ovr, m_prev_adv;
    int  cyc = 0, acc_cyc = 0, strobe_cyc = 0, n_strobe = 0;

    // Frame index stored at read address a.
    function automatic int fmap(input int a);
        int r;
        r = a;
`ifdef SFFT_FRAME_BITREV_EN
        r = 0;
        for (int i = 0; i < N_LOG; i++) begin
            if (((a >> i) & 1) != 0) r = r | (1 << (N_LOG - 1 - i));
        end
`endif
        return r;
    endfunction

    // Push one sample into the history; returns 1 when a frame is due.
    function automatic bit m_commit(input logic [SW-1:0] v);
        m_ring.push_back(v);
        if (m_ring.size() > NFFT) void'(m_ring.pop_front());
        m_hop++;
        if (m_ring.size() == NFFT && m_hop >= HOP) begin
            m_hop = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_swap();
        for (int i = 0; i < NFFT; i++) m_front[i] = m_snap[i];
        m_valid  = 1'b1;
        m_strobe = 1'b1;
    endtask

    // Predict the outputs seen after the coming clock edge.
    task automatic model_cycle();
        bit accept, copying, trig;
        if (reset) begin
            m_ring.delete(); m_skid.delete();
            m_hop = 0; m_copy_rem = 0; m_drop = 0;
            m_wait = 0; m_valid = 0; m_strobe = 0; m_ovr = 0; m_prev_adv = 0;
            m_out = '0;
            return;
        end
        accept     = advanceSignal && !m_prev_adv;
        m_prev_adv = advanceSignal;
        if (accept) acc_cyc = cyc;
        m_out    = m_valid ? m_front[fmap(int'(output_address))] : '0;
        copying  = (m_copy_rem > 0);
        trig     = 1'b0;
        m_strobe = 1'b0;
        if (!copying) begin
            if (m_skid.size() > 0) begin
                trig = m_commit(m_skid.pop_front());
                if (accept) m_skid.push_back(sample);
            end else if (accept) begin
                trig = m_commit(sample);
            end
        end else if (accept) begin
            if (m_skid.size() == 0) m_skid.push_back(sample);
            else m_ovr = 1'b1;
        end
        if (copying) begin
            m_copy_rem--;
            if (m_copy_rem == 0) begin
                if (!OutputBeingRead) m_swap();
                else m_wait = 1'b1;
            end
        end else begin
            if (m_wait && !OutputBeingRead) begin
                m_swap();
                m_wait = 1'b0;
            end
            if (trig) begin
                if (m_wait) begin
                    if (m_drop < 255) m_drop++;
                    m_wait = 1'b0;
                end
                for (int i = 0; i < NFFT; i++) m_snap[i] = m_ring[i];
                m_copy_rem = NFFT;
            end
        end
    endtask

    // One clock: model, edge, compare every output.
    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (FrameStrobe) begin
            strobe_cyc = cyc;
            n_strobe++;
        end
        check("sample_out", {8'd0, FrameSampleOut}, {8'd0, m_out});
        check("valid", 32'(FrameValid), 32'(m_valid));
        check("strobe", 32'(FrameStrobe), 32'(m_strobe));
        check("drop_count", 32'(FrameDropCount), 32'(m_drop));
        check("overrun", 32'(Overrun), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        advanceSignal = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int v);
        sample        = SW'(v);
        advanceSignal = 1'b1;
        step();
        advanceSignal = 1'b0;
        step();
    endtask

    task automatic pulses(input int first, input int last);
        for (int v = first; v <= last; v++) pulse(v);
    endtask

    task automatic wait_strobe();
        int k;
        k = 0;
        advanceSignal = 1'b0;
        while (!FrameStrobe && k < 20) begin
            step();
            k++;
        end
    endtask

    // Read the whole front bank and compare with the expected frame base..base+7.
    task automatic read_frame(input int base);
        for (int a = 0; a < NFFT; a++) begin
            output_address = N_LOG'(a);
            step();
            check("frame_read", {8'd0, FrameSampleOut}, 32'(base + fmap(a)));
        end
    endtask

    initial begin
        int n0;
        step();
        step();
        check("reset_out", {8'd0, FrameSampleOut}, 32'd0);
        check("reset_valid", 32'(FrameValid), 32'd0);
        reset = 1'b0;

        // First frame: samples 1..8.
        pulses(1, 8);
        wait_strobe();
        check("strobe_latency", 32'(strobe_cyc - acc_cyc), 32'd9);
        check("valid_after_frame", 32'(FrameValid), 32'd1);
        read_frame(1);

        // Hop of four: no frame until the fourth new sample.
        n0 = n_strobe;
        pulses(9, 11);
        idle(10);
        check("no_early_strobe", 32'(n_strobe - n0), 32'd0);
        pulse(12);
        wait_strobe();
        read_frame(5);

        // Consumer holds the front bank through a trigger.
        OutputBeingRead = 1'b1;
        n0 = n_strobe;
        pulses(13, 16);
        idle(12);
        check("held_no_strobe", 32'(n_strobe - n0), 32'd0);
        read_frame(5);
        OutputBeingRead = 1'b0;
        step();
        check("release_strobe", 32'(FrameStrobe), 32'd1);
        read_frame(9);

        // Two triggers while held: the older pending frame is dropped.
        OutputBeingRead = 1'b1;
        pulses(17, 20);
        idle(12);
        pulses(21, 24);
        idle(12);
        check("drop_one", 32'(FrameDropCount), 32'd1);
        OutputBeingRead = 1'b0;
        step();
        read_frame(17);

        // Two samples inside one COPY, then reset mid-COPY.
        pulses(25, 28);
        pulse(29);
        pulse(30);
        check("overrun_set", 32'(Overrun), 32'd1);
        reset = 1'b1;
        step();
        check("rst_copy_out", {8'd0, FrameSampleOut}, 32'd0);
        check("rst_copy_valid", 32'(FrameValid), 32'd0);
        check("rst_copy_overrun", 32'(Overrun), 32'd0);
        check("rst_copy_drop", 32'(FrameDropCount), 32'd0);
        reset = 1'b0;
        n0 = n_strobe;
        pulses(31, 37);
        idle(20);
        check("refill_no_strobe", 32'(n_strobe - n0), 32'd0);
        pulse(38);
        wait_strobe();
        check("refill_latency", 32'(strobe_cyc - acc_cyc), 32'd9);
        read_frame(31);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 699) == 0);
            advanceSignal = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 19) == 0) OutputBeingRead = ~OutputBeingRead;
            output_address = N_LOG'($urandom_range(0, NFFT - 1));
            sample         = SW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
